dm_access_ctrl: RTL and testbench
=================================

DM_ACCESS_CTRL -- requirements
Module: dm_access_ctrl

Interface
REQ-001 Parameter MEM_BYTES, default 32: byte depth of the attached data memory.
REQ-002 clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req0_valid / req1_valid  input  1  requester n holds an access pending.
REQ-005 req0_we / req1_we  input  1  1 = word store, 0 = word load.
REQ-006 req0_addr / req1_addr  input  32  byte address of word (lowest byte).
REQ-007 req0_wdata / req1_wdata  input  32  store data.
REQ-008 req0_ready / req1_ready  output  1  one-cycle accept pulse to requester n.
REQ-009 req0_done / req1_done  output  1  one-cycle completion pulse to requester n.
REQ-010 rdata  output  32  load result, valid in the done cycle.
REQ-011 err  output  1  out-of-range flag, valid in the done cycle.
REQ-012 mem_re, mem_we  output  1  byte read/write strobes to data memory.
REQ-013 mem_addr  output  32  byte address to data memory.
REQ-014 mem_wdata  output  8  byte write data; mem_rdata  input  8  combinational byte read data.

Function
REQ-015 FSM states SHALL be IDLE, XFER, DONE.
REQ-016 IDLE: if any valid, grant one requester per REQ-030; pulse its ready that cycle; latch we, addr, wdata, grant id; go to XFER with beat=0.
REQ-017 XFER: SHALL run exactly 4 beats (beat 0..3, 2-bit counter); beat k drives mem_addr=addr+k.
REQ-018 Store beat k: mem_we=1, mem_wdata=wdata[8k+7:8k]; memory commits at the clock edge ending the beat.
REQ-019 Load beat k: mem_re=1; rdata[8k+7:8k] captured from mem_rdata at the edge ending the beat (little-endian).
REQ-020 After beat 3, go to DONE; DONE pulses done of the granted requester, drives rdata (0 for stores) and err, returns to IDLE.
REQ-021 Latency: accept in cycle N, beats N+1..N+4, done in N+5; next accept no earlier than N+6.
REQ-022 Range check in IDLE: if addr > MEM_BYTES-4, no mem strobe SHALL assert; FSM goes IDLE->DONE directly with err=1, rdata=0.
REQ-023 Unaligned in-range addresses SHALL be serviced normally; no address wrap-around.
REQ-024 mem_re, mem_we SHALL be 0 outside XFER; never both 1.
REQ-025 Requester inputs SHALL be ignored outside IDLE; a valid dropped before ready is simply not serviced.
REQ-026 ready, done SHALL never assert for both requesters in the same cycle.

Reset
REQ-027 reset SHALL force state IDLE, beat=0, all ready/done/err/mem_re/mem_we=0, rdata=0, round-robin pointer favouring req0.
REQ-028 Reset mid-XFER SHALL abort immediately; no further strobes; bytes already written remain; no done pulse.
REQ-029 First accept after reset release no earlier than the first posedge with reset low.

Configuration
REQ-030 Macro DM_ARB_RR_EN defined: round-robin, requester not granted last wins on a tie; undefined: fixed priority, req0 always wins on a tie.
REQ-031 Either way, a sole valid requester SHALL be granted in its first IDLE cycle.

Verification
REQ-032 req0 store addr=4 wdata=0xDDCCBBAA -> bytes 4..7 = AA,BB,CC,DD; req0_done at N+5, err=0.
REQ-033 req1 load addr=4 after REQ-032 -> rdata=0xDDCCBBAA with req1_done, mem_we never 1.
REQ-034 Both valid continuously, 4 accesses -> with DM_ARB_RR_EN grants 0,1,0,1; without, 0,0,0,0.
REQ-035 req0 load addr=29 (MEM_BYTES=32) -> no mem strobes, done at N+1 relative to accept, err=1, rdata=0.
REQ-036 reset asserted during beat 2 of store addr=0 data 0x44332211 -> bytes 0,1 = 11,22, bytes 2,3 unchanged, no done, outputs 0.

Source files
------------

// File: rtl/dm_access_if.sv
// Bundled requester and data-memory signals for the dual-requester data-memory access controller.
interface dm_access_if;
  logic        req0_valid;
  logic        req0_we;
  logic [31:0] req0_addr;
  logic [31:0] req0_wdata;
  logic        req0_ready;
  logic        req0_done;

  logic        req1_valid;
  logic        req1_we;
  logic [31:0] req1_addr;
  logic [31:0] req1_wdata;
  logic        req1_ready;
  logic        req1_done;

  logic [31:0] rdata;
  logic        err;

  logic        mem_re;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  modport slave (
    input  req0_valid, req0_we, req0_addr, req0_wdata,
    input  req1_valid, req1_we, req1_addr, req1_wdata,
    input  mem_rdata,
    output req0_ready, req0_done, req1_ready, req1_done,
    output rdata, err,
    output mem_re, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req0_valid, req0_we, req0_addr, req0_wdata,
    output req1_valid, req1_we, req1_addr, req1_wdata,
    output mem_rdata,
    input  req0_ready, req0_done, req1_ready, req1_done,
    input  rdata, err,
    input  mem_re, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dm_access_ctrl.sv
// Two-requester word access controller over a byte-wide data memory (4 beats per word).
// Define DM_ARB_RR_EN for round-robin arbitration; otherwise req0 has fixed priority.
module dm_access_ctrl #(
  parameter int MEM_BYTES = 32
) (
  input  logic         clk,
  input  logic         reset,
  dm_access_if.slave   bus
);

  localparam logic [31:0] MAX_ADDR = 32'(MEM_BYTES - 4);

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

  state_t      state_q, state_d;
  logic [1:0]  beat_q;
  logic        gnt_q;
  logic        err_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;

  logic        any_valid;
  logic        accept;
  logic        gnt_id;
  logic        sel_we;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic        out_of_range;

  assign any_valid = bus.req0_valid | bus.req1_valid;
  // Holding off while reset is high keeps ready from pulsing on an accept that cannot happen.
  assign accept    = (state_q == IDLE) & any_valid & ~reset;

`ifdef DM_ARB_RR_EN
  logic last_q;
  assign gnt_id = (bus.req0_valid & bus.req1_valid) ? ~last_q : bus.req1_valid;
`else
  assign gnt_id = ~bus.req0_valid;
`endif

  assign sel_we       = gnt_id ? bus.req1_we    : bus.req0_we;
  assign sel_addr     = gnt_id ? bus.req1_addr  : bus.req0_addr;
  assign sel_wdata    = gnt_id ? bus.req1_wdata : bus.req0_wdata;
  assign out_of_range = sel_addr > MAX_ADDR;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      beat_q  <= 2'd0;
      gnt_q   <= 1'b0;
      err_q   <= 1'b0;
`ifdef DM_ARB_RR_EN
      last_q  <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      if (accept) begin
        gnt_q  <= gnt_id;
        err_q  <= out_of_range;
        beat_q <= 2'd0;
`ifdef DM_ARB_RR_EN
        last_q <= gnt_id;
`endif
      end else if (state_q == XFER) begin
        beat_q <= beat_q + 2'd1;
      end
    end
  end

  // Transaction data: masked at the outputs by state, so it needs no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      we_q    <= sel_we;
      addr_q  <= sel_addr;
      wdata_q <= sel_wdata;
      rdata_q <= 32'd0;
    end else if (state_q == XFER && !we_q) begin
      rdata_q[{beat_q, 3'b000} +: 8] <= bus.mem_rdata;
    end
  end

  always_comb begin
    state_d        = state_q;
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    bus.req0_done  = 1'b0;
    bus.req1_done  = 1'b0;
    bus.rdata      = 32'd0;
    bus.err        = 1'b0;
    bus.mem_re     = 1'b0;
    bus.mem_we     = 1'b0;
    bus.mem_addr   = 32'd0;
    bus.mem_wdata  = 8'd0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          bus.req0_ready = ~gnt_id;
          bus.req1_ready = gnt_id;
          state_d        = out_of_range ? DONE : XFER;
        end
      end
      XFER: begin
        bus.mem_addr  = addr_q + {30'd0, beat_q};
        bus.mem_we    = we_q;
        bus.mem_re    = ~we_q;
        bus.mem_wdata = wdata_q[{beat_q, 3'b000} +: 8];
        if (beat_q == 2'd3) state_d = DONE;
      end
      DONE: begin
        bus.req0_done = ~gnt_q;
        bus.req1_done = gnt_q;
        bus.rdata     = we_q ? 32'd0 : rdata_q;
        bus.err       = err_q;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Directed bench for dm_access_ctrl with a 32-byte behavioural data memory.
module tb_dm_access_ctrl;

  logic clk = 1'b0;
  logic reset;
  logic mem_init;

  dm_access_if bus();

  dm_access_ctrl #(.MEM_BYTES(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [0:31];

  assign bus.mem_rdata = (bus.mem_addr < 32'd32) ? mem[bus.mem_addr[4:0]] : 8'h00;

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 32; i++) mem[i] <= 8'(8'h80 + i);
    end else if (bus.mem_we && bus.mem_addr < 32'd32) begin
      mem[bus.mem_addr[4:0]] <= bus.mem_wdata;
    end
  end

  int cyc = 0;
  int re_cnt = 0, we_cnt = 0, done_cnt = 0, viol = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.mem_re) re_cnt <= re_cnt + 1;
    if (bus.mem_we) we_cnt <= we_cnt + 1;
    if (bus.req0_done || bus.req1_done) done_cnt <= done_cnt + 1;
    if ((bus.mem_re && bus.mem_we) || (bus.req0_ready && bus.req1_ready) ||
        (bus.req0_done && bus.req1_done)) viol <= viol + 1;
  end

  int n_pass = 0, n_total = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic drive(input int id, input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    if (id == 0) begin
      bus.req0_valid = 1'b1; bus.req0_we = we; bus.req0_addr = addr; bus.req0_wdata = wdata;
    end else begin
      bus.req1_valid = 1'b1; bus.req1_we = we; bus.req1_addr = addr; bus.req1_wdata = wdata;
    end
  endtask

  task automatic idle_reqs();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
  endtask

  task automatic wait_done(output int dc, output int id, output logic [31:0] rd, output logic e);
    dc = -1000; id = -1; rd = 32'hxxxxxxxx; e = 1'bx;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.req0_done || bus.req1_done) begin
        dc = cyc; id = bus.req1_done ? 1 : 0; rd = bus.rdata; e = bus.err;
        break;
      end
    end
  endtask

  // Called just after a rising edge; returns just after the rising edge following done.
  task automatic single(input int id, input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        output logic acc, output int lat, output int did,
                        output logic [31:0] rd, output logic e);
    int n, dc;
    drive(id, we, addr, wdata);
    @(negedge clk);
    acc = (id == 0) ? (bus.req0_ready && !bus.req1_ready) : (bus.req1_ready && !bus.req0_ready);
    n = cyc;
    @(posedge clk); #1;
    idle_reqs();
    wait_done(dc, did, rd, e);
    lat = dc - n;
    @(posedge clk); #1;
  endtask

  logic acc, e;
  int lat, did;
  logic [31:0] rd;
  int re0, we0, dn0;
  int gid [4];
  int gcyc [4];
  int na;
  int exp_g [4];
  logic [31:0] exp_last_rd;

  initial begin
    reset = 1'b1;
    mem_init = 1'b1;
    idle_reqs();
    bus.req0_we = 1'b0; bus.req0_addr = 32'd0; bus.req0_wdata = 32'd0;
    bus.req1_we = 1'b0; bus.req1_addr = 32'd0; bus.req1_wdata = 32'd0;
    @(posedge clk); #1;
    mem_init = 1'b0;
    drive(0, 1'b1, 32'd4, 32'hDDCCBBAA);
    @(negedge clk);
    chk("reset_ready0", {31'd0, bus.req0_ready}, 32'd0);
    chk("reset_strobes", {30'd0, bus.mem_re, bus.mem_we}, 32'd0);
    chk("reset_done_err", {29'd0, bus.req0_done, bus.req1_done, bus.err}, 32'd0);
    chk("reset_rdata", bus.rdata, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    re0 = re_cnt; we0 = we_cnt;

    // req0 word store at 4
    single(0, 1'b1, 32'd4, 32'hDDCCBBAA, acc, lat, did, rd, e);
    chk("store_accept", {31'd0, acc}, 32'd1);
    chk("store_latency", 32'(lat), 32'd5);
    chk("store_done_id", 32'(did), 32'd0);
    chk("store_err", {31'd0, e}, 32'd0);
    chk("store_rdata", rd, 32'd0);
    chk("store_bytes", {mem[7], mem[6], mem[5], mem[4]}, 32'hDDCCBBAA);
    chk("store_neighbours", {16'd0, mem[8], mem[3]}, 32'h00008883);
    chk("store_we_beats", 32'(we_cnt - we0), 32'd4);
    chk("store_re_beats", 32'(re_cnt - re0), 32'd0);

    // req1 word load at 4
    re0 = re_cnt; we0 = we_cnt;
    single(1, 1'b0, 32'd4, 32'h0, acc, lat, did, rd, e);
    chk("load_accept", {31'd0, acc}, 32'd1);
    chk("load_latency", 32'(lat), 32'd5);
    chk("load_done_id", 32'(did), 32'd1);
    chk("load_rdata", rd, 32'hDDCCBBAA);
    chk("load_err", {31'd0, e}, 32'd0);
    chk("load_we_beats", 32'(we_cnt - we0), 32'd0);
    chk("load_re_beats", 32'(re_cnt - re0), 32'd4);

    // out-of-range load at 29
    re0 = re_cnt; we0 = we_cnt;
    single(0, 1'b0, 32'd29, 32'h0, acc, lat, did, rd, e);
    chk("oor_accept", {31'd0, acc}, 32'd1);
    chk("oor_latency", 32'(lat), 32'd1);
    chk("oor_err", {31'd0, e}, 32'd1);
    chk("oor_rdata", rd, 32'd0);
    chk("oor_strobes", 32'((re_cnt - re0) + (we_cnt - we0)), 32'd0);

    // highest in-range address
    single(0, 1'b0, 32'd28, 32'h0, acc, lat, did, rd, e);
    chk("edge28_latency", 32'(lat), 32'd5);
    chk("edge28_err", {31'd0, e}, 32'd0);
    chk("edge28_rdata", rd, 32'h9F9E9D9C);

    // unaligned load by req1
    single(1, 1'b0, 32'd5, 32'h0, acc, lat, did, rd, e);
    chk("unaligned_done_id", 32'(did), 32'd1);
    chk("unaligned_rdata", rd, 32'h88DDCCBB);

    // both requesters continuously valid
    drive(0, 1'b0, 32'd0, 32'h0);
    drive(1, 1'b0, 32'd8, 32'h0);
    na = 0;
    for (int i = 0; i < 40 && na < 4; i++) begin
      @(negedge clk);
      if (bus.req0_ready || bus.req1_ready) begin
        gid[na] = bus.req1_ready ? 1 : 0;
        gcyc[na] = cyc;
        na++;
      end
    end
    @(posedge clk); #1;
    idle_reqs();
    wait_done(lat, did, rd, e);
`ifdef DM_ARB_RR_EN
    exp_g = '{0, 1, 0, 1};
    exp_last_rd = 32'h8B8A8988;
`else
    exp_g = '{0, 0, 0, 0};
    exp_last_rd = 32'h83828180;
`endif
    chk("arb_count", 32'(na), 32'd4);
    for (int i = 0; i < 4; i++) chk($sformatf("arb_grant%0d", i), 32'(gid[i]), 32'(exp_g[i]));
    chk("arb_accept_gap", 32'(gcyc[1] - gcyc[0]), 32'd6);
    chk("arb_last_done_id", 32'(did), 32'(exp_g[3]));
    chk("arb_last_rdata", rd, exp_last_rd);
    @(posedge clk); #1;

    // reset during beat 2 of a store at 0
    drive(0, 1'b1, 32'd0, 32'h44332211);
    @(negedge clk);
    chk("abort_accept", {31'd0, bus.req0_ready}, 32'd1);
    @(posedge clk); #1;
    idle_reqs();
    @(posedge clk); #1;
    @(negedge clk);
    chk("abort_beat1", {bus.mem_wdata, 15'd0, bus.mem_we, bus.mem_addr[7:0]}, 32'h22000101);
    @(posedge clk); #1;
    reset = 1'b1;
    dn0 = done_cnt;
    #1;
    chk("abort_strobes", {30'd0, bus.mem_re, bus.mem_we}, 32'd0);
    chk("abort_outputs", {29'd0, bus.req0_done, bus.req1_done, bus.err}, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("abort_no_done", 32'(done_cnt - dn0), 32'd0);
    chk("abort_bytes", {mem[3], mem[2], mem[1], mem[0]}, 32'h83822211);
    chk("exclusive_violations", 32'(viol), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
